// File: rtl/mc_maindec.sv
// Multicycle main decoder: FSM over fetch/decode/execute/memory/writeback,
// per-state datapath controls, retired counter and sticky illegal flag.
module mc_maindec #(
  parameter int ALUOP_W  = 3,
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op_c,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic               ir_we,
  output logic               iord,
  output logic               mem_we,
  output logic               we_c,
  output logic [1:0]         dest_reg_c,
  output logic [1:0]         result_c,
  output logic               argA_c,
  output logic [1:0]         argB_c,
  output logic [1:0]         ext_c,
  output logic               sh_d_c,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] aluop,
  output logic [3:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_IMM_EX = 4'd8;
  localparam logic [3:0] S_IMM_WB = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_JR     = 4'd13;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  logic [3:0] cur, nxt;
  logic       mr;

  logic is_r, is_lw, is_sw, is_j, is_jal, is_beq, is_bne;
  logic is_addi, is_lui, is_ori, is_slti, is_andi;
  logic is_imm, is_known, is_jr, is_shift;

  assign mr = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  assign is_r     = op_c == OP_R;
  assign is_lw    = op_c == OP_LW;
  assign is_sw    = op_c == OP_SW;
  assign is_j     = op_c == OP_J;
  assign is_jal   = op_c == OP_JAL;
  assign is_beq   = op_c == OP_BEQ;
  assign is_bne   = op_c == OP_BNE;
  assign is_addi  = op_c == OP_ADDI;
  assign is_lui   = op_c == OP_LUI;
  assign is_ori   = op_c == OP_ORI;
  assign is_slti  = op_c == OP_SLTI;
  assign is_andi  = op_c == OP_ANDI;
  assign is_imm   = is_addi | is_lui | is_ori | is_slti | is_andi;
  assign is_known = is_r | is_lw | is_sw | is_j | is_jal
                  | is_beq | is_bne | is_imm;
  assign is_jr    = funct == FN_JR;
  assign is_shift = (funct == FN_SLL) | (funct == FN_SRL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (mr) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw | is_sw:   nxt = S_MEMADR;
          is_r & is_jr:    nxt = S_JR;
          is_r & ~is_jr:   nxt = S_EXEC_R;
          is_beq | is_bne: nxt = S_BRANCH;
          is_imm:          nxt = S_IMM_EX;
          is_j:            nxt = S_JUMP;
          is_jal:          nxt = S_JAL;
          default:         nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mr) nxt = S_MEMWB;
      S_MEMWR:  if (mr) nxt = S_FETCH;
      S_EXEC_R: nxt = S_ALUWB;
      S_IMM_EX: nxt = S_IMM_WB;
      S_MEMWB, S_ALUWB, S_IMM_WB, S_BRANCH,
      S_JUMP, S_JAL, S_JR: nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // DECODE falls back to FETCH for unknown opcodes; that is not a retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      if (nxt == S_FETCH && cur != S_FETCH && cur != S_DECODE)
        retired <= retired + CNT_W'(1);
      if (cur == S_DECODE && !is_known)
        illegal <= 1'b1;
    end
  end

  logic [1:0] imm_ext;
  logic [2:0] imm_alu;

  always_comb begin
    imm_ext = 2'b00;
    imm_alu = 3'b000;
    unique case (1'b1)
      is_lui:  imm_ext = 2'b01;
      is_ori:  begin imm_ext = 2'b10; imm_alu = 3'b010; end
      is_slti: imm_alu = 3'b011;
      is_andi: begin imm_ext = 2'b10; imm_alu = 3'b100; end
      default: ;
    endcase
  end

  logic       pc_we_s, ir_we_s, mem_we_s, we_s;
  logic [2:0] a3;

  always_comb begin
    pc_we_s    = 1'b0;
    ir_we_s    = 1'b0;
    mem_we_s   = 1'b0;
    we_s       = 1'b0;
    iord       = 1'b0;
    dest_reg_c = 2'b00;
    result_c   = 2'b00;
    argA_c     = 1'b0;
    argB_c     = 2'b00;
    ext_c      = 2'b00;
    sh_d_c     = 1'b0;
    pc_src     = 2'b00;
    a3         = 3'b000;
    case (cur)
      S_FETCH: begin
        argB_c  = 2'b01;
        ir_we_s = mr;
        pc_we_s = mr;
      end
      S_DECODE: argB_c = 2'b11;
      S_MEMADR: begin
        argA_c = 1'b1;
        argB_c = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        we_s       = 1'b1;
        dest_reg_c = 2'b01;
        result_c   = 2'b01;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        mem_we_s = 1'b1;
      end
      S_EXEC_R: begin
        argA_c = 1'b1;
        a3     = 3'b111;
        sh_d_c = is_shift;
      end
      S_ALUWB: begin
        we_s     = 1'b1;
        result_c = is_shift ? 2'b10 : 2'b00;
        sh_d_c   = is_shift;
      end
      S_IMM_EX: begin
        argA_c = 1'b1;
        argB_c = 2'b10;
        ext_c  = imm_ext;
        a3     = imm_alu;
      end
      S_IMM_WB: begin
        we_s       = 1'b1;
        dest_reg_c = 2'b01;
        ext_c      = imm_ext;
        a3         = imm_alu;
      end
      S_BRANCH: begin
        argA_c  = 1'b1;
        a3      = 3'b001;
        pc_src  = 2'b01;
        pc_we_s = (is_beq & zero) | (is_bne & ~zero);
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_we_s = 1'b1;
      end
      S_JAL: begin
        pc_src     = 2'b10;
        pc_we_s    = 1'b1;
        we_s       = 1'b1;
        dest_reg_c = 2'b10;
        result_c   = 2'b11;
      end
      S_JR: begin
        pc_src  = 2'b11;
        pc_we_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces FETCH at once; gating keeps FETCH from strobing enables.
  assign pc_we  = pc_we_s & ~rst;
  assign ir_we  = ir_we_s & ~rst;
  assign mem_we = mem_we_s & ~rst;
  assign we_c   = we_s & ~rst;
  assign aluop  = ALUOP_W'(a3);
  assign state  = cur;

endmodule
